serial_and_rx: RTL and testbench
================================

SERIAL_AND_RX -- requirements
Module: serial_and_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the number of bits per operand; legal range 1..32.
REQ-002 The block SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port RESET, input, 1, reset that is synchronous to CLK and active-high.
REQ-004 The block SHALL have port START, input, 1, marking the first (LSB) bit of a frame when sampled with BIT_VALID.
REQ-005 The block SHALL have port BIT_VALID, input, 1, qualifying I0_S/I1_S on this cycle.
REQ-006 The block SHALL have ports I0_S and I1_S, input, 1 each, the serial operand lanes, LSB first.
REQ-007 The block SHALL have port O, output, WIDTH, the bitwise AND of the last completed operand pair.
REQ-008 The block SHALL have port O_VALID, output, 1, a one-cycle pulse when O is updated.
REQ-009 The block SHALL have port BUSY, output, 1, high while a frame is partially received.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-011 In IDLE, START=1 with BIT_VALID=1 SHALL capture bit 0 of both lanes, load the bit counter with 1 and go to SHIFT; in IDLE, BIT_VALID without START SHALL be ignored.
REQ-012 In SHIFT, each BIT_VALID=1 cycle SHALL capture one bit per lane into position equal to the counter and increment the counter; cycles with BIT_VALID=0 SHALL hold all state.
REQ-013 When bit WIDTH-1 is captured, the FSM SHALL go to DONE on the next edge.
REQ-014 DONE SHALL last exactly one cycle: O is loaded with the bitwise AND of the two shift registers and O_VALID=1, then the FSM returns to IDLE.
REQ-015 Latency SHALL be one cycle from the edge that captures the last bit to O_VALID=1.
REQ-016 WIDTH=1 SHALL go from IDLE directly to DONE on the START bit.
REQ-017 START=1 with BIT_VALID=1 while in SHIFT SHALL abandon the partial frame without asserting O_VALID and restart at bit 0 with the current bits.
REQ-018 START in DONE SHALL be treated as in IDLE on the same cycle, so back-to-back frames need no gap.
REQ-019 O SHALL hold its value between O_VALID pulses; an abandoned frame SHALL NOT change O.
REQ-020 BUSY SHALL be 1 exactly in SHIFT.

Reset
REQ-021 RESET=1 at a rising edge SHALL force state IDLE, counter 0, shift registers 0, O=0, O_VALID=0, BUSY=0, regardless of other inputs.
REQ-022 RESET asserted mid-frame SHALL discard the frame; the first frame after reset SHALL require a new START.

Configuration
REQ-023 With macro SERIAL_AND_RX_PARITY_EN defined, each frame SHALL carry one extra even-parity bit per lane after bit WIDTH-1, covering that lane's WIDTH data bits, and the block SHALL add output PAR_ERR, 1 bit.
REQ-024 With the macro defined, a parity mismatch on either lane SHALL suppress O_VALID, leave O unchanged, and pulse PAR_ERR for one cycle in DONE; PAR_ERR SHALL reset to 0.
REQ-025 Without the macro, frames SHALL be exactly WIDTH bits and PAR_ERR SHALL not exist.

Structure
REQ-026 The FSM state enum and a counter-width constant of clog2(WIDTH+1) SHALL be defined in the shared package serial_and_pkg.
REQ-027 The lane deserializer SHALL be a sub-module sipo_reg with parameter WIDTH and inputs CLK, RESET, load-enable, bit index and serial bit; it SHALL be instantiated once per lane.

Verification (WIDTH=2 unless stated)
REQ-028 The bench SHALL cover this case: I0_S bits 1,1 and I1_S bits 1,0, LSB first, on consecutive cycles with START on the first -> O=2'b01 and O_VALID pulses once, one cycle after the second bit.
REQ-029 The bench SHALL cover this case: the same frame with BIT_VALID=0 for 3 cycles between the bits -> same O=2'b01, BUSY=1 throughout the gap.
REQ-030 The bench SHALL cover this case: frame A (11/11) abandoned after 1 bit by START of frame B (10/11) -> single O_VALID with O=2'b10.
REQ-031 The bench SHALL cover this case: RESET for 1 cycle mid-frame -> O=0 and BUSY=0; the following non-START bits produce no O_VALID.
REQ-032 The bench SHALL cover this case: two frames back-to-back with START in DONE -> two O_VALID pulses 2 cycles apart with the correct values.
REQ-033 The bench SHALL cover this case: with SERIAL_AND_RX_PARITY_EN defined, lane I0 data 1,1 with parity 1 -> PAR_ERR=1, no O_VALID, and O unchanged.

Source files
------------

// File: rtl/serial_and_pkg.sv
// Shared types and sizing helpers for the serial AND receiver.
// Optional feature macro: SERIAL_AND_RX_PARITY_EN (adds one even-parity bit per lane).
package serial_and_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width able to hold 0..w, clog2(w+1).
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned DEFAULT_WIDTH = 2;
    localparam int unsigned CNT_W         = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_and_rx_if.sv
// Serial operand bus for serial_and_rx: frame control, two serial lanes and the result.
// With SERIAL_AND_RX_PARITY_EN defined the bus also carries PAR_ERR.
interface serial_and_rx_if #(
    parameter int WIDTH = 2
);
    logic             START;
    logic             BIT_VALID;
    logic             I0_S;
    logic             I1_S;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             BUSY;
`ifdef SERIAL_AND_RX_PARITY_EN
    logic             PAR_ERR;

    modport master (
        output START, BIT_VALID, I0_S, I1_S,
        input  O, O_VALID, BUSY, PAR_ERR
    );

    modport slave (
        input  START, BIT_VALID, I0_S, I1_S,
        output O, O_VALID, BUSY, PAR_ERR
    );
`else
    modport master (
        output START, BIT_VALID, I0_S, I1_S,
        input  O, O_VALID, BUSY
    );

    modport slave (
        input  START, BIT_VALID, I0_S, I1_S,
        output O, O_VALID, BUSY
    );
`endif
endinterface

// File: rtl/serial_and_rx_sipo.sv
// sipo_reg: one lane deserializer; writes the serial bit into the position given by the index.
module sipo_reg
    import serial_and_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      load_en_i,
    input  logic [cnt_w(WIDTH)-1:0]   idx_i,
    input  logic                      bit_i,
    output logic [WIDTH-1:0]          q_o
);

    localparam int unsigned IW = cnt_w(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;

    // Positional write; indices past WIDTH-1 (parity slot) leave the data untouched.
    always_comb begin
        q_d = q_q;
        if (load_en_i) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (idx_i == IW'(i)) q_d[i] = bit_i;
            end
        end
    end

    // Data register with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RESET) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_and_rx.sv
// serial_and_rx: deserializes two LSB-first lanes and presents their bitwise AND.
// Optional macro SERIAL_AND_RX_PARITY_EN: one trailing even-parity bit per lane and PAR_ERR.
module serial_and_rx
    import serial_and_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    serial_and_rx_if.slave  bus
);

    localparam int unsigned CW = cnt_w(WIDTH);
`ifdef SERIAL_AND_RX_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] sr0, sr1;
    logic             load_en;
    logic [CW-1:0]    idx;
    logic             start_frame;
    logic             o_valid;
`ifdef SERIAL_AND_RX_PARITY_EN
    logic             p0_q, p1_q;
    logic             par_bad;
    logic             par_err;
`endif

    sipo_reg #(.WIDTH(WIDTH)) u_sipo0 (
        .CLK       (CLK),
        .RESET     (RESET),
        .load_en_i (load_en),
        .idx_i     (idx),
        .bit_i     (bus.I0_S),
        .q_o       (sr0)
    );

    sipo_reg #(.WIDTH(WIDTH)) u_sipo1 (
        .CLK       (CLK),
        .RESET     (RESET),
        .load_en_i (load_en),
        .idx_i     (idx),
        .bit_i     (bus.I1_S),
        .q_o       (sr1)
    );

    assign start_frame = bus.START & bus.BIT_VALID;

`ifdef SERIAL_AND_RX_PARITY_EN
    // Even parity over data plus parity bit must come out zero on both lanes.
    assign par_bad = (^sr0 ^ p0_q) | (^sr1 ^ p1_q);
`endif

    // Next-state, capture control and result selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_en = 1'b0;
        idx     = '0;
        o_d     = o_q;
        o_valid = 1'b0;
`ifdef SERIAL_AND_RX_PARITY_EN
        par_err = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
`ifdef SERIAL_AND_RX_PARITY_EN
                    if (par_bad) begin
                        par_err = 1'b1;
                    end else begin
                        o_valid = 1'b1;
                        o_d     = sr0 & sr1;
                    end
`else
                    o_valid = 1'b1;
                    o_d     = sr0 & sr1;
`endif
                end
                state_d = IDLE;
                cnt_d   = '0;
                // DONE also accepts a new START so frames can run back to back.
                if (start_frame) begin
                    load_en = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = (FRAME_LEN == 1) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (start_frame) begin
                    load_en = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end else if (bus.BIT_VALID) begin
                    load_en = 1'b1;
                    idx     = cnt_q;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(FRAME_LEN - 1)) state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and held result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

`ifdef SERIAL_AND_RX_PARITY_EN
    // Parity bits occupy index WIDTH of each frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            p0_q <= 1'b0;
            p1_q <= 1'b0;
        end else if (load_en && idx == CW'(WIDTH)) begin
            p0_q <= bus.I0_S;
            p1_q <= bus.I1_S;
        end
    end

    assign bus.PAR_ERR = par_err;
`endif

    assign bus.O       = o_d;
    assign bus.O_VALID = o_valid;
    assign bus.BUSY    = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_and_rx.sv
// Self-checking bench for serial_and_rx (WIDTH=2), directed cases plus random traffic
// checked against a frame-level reference model. Honours SERIAL_AND_RX_PARITY_EN.
module tb_serial_and_rx;

    localparam int W = 2;
`ifdef SERIAL_AND_RX_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic CLK;
    logic RESET;

    serial_and_rx_if #(.WIDTH(W)) bus ();

    serial_and_rx #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_pulse = -1;
    int prev_pulse = -1;

    // Reference model state: bits gathered for the current frame as plain integers.
    bit          active = 0;
    int unsigned n = 0;
    int unsigned v0 = 0, v1 = 0;
    logic [W-1:0] m_o = '0;
    bit          m_valid = 0, m_busy = 0, m_perr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit rst, input bit st, input bit bv, input bit b0, input bit b1);
        bit err;
        m_valid = 0;
        m_perr  = 0;
        if (rst) begin
            active = 0; n = 0; v0 = 0; v1 = 0; m_o = '0; m_busy = 0;
            return;
        end
        if (bv && st) begin
            v0 = int'(b0); v1 = int'(b1); n = 1; active = 1;
        end else if (bv && active) begin
            v0 = v0 | (int'(b0) << n);
            v1 = v1 | (int'(b1) << n);
            n++;
        end
        if (active && n == FLEN) begin
            active = 0;
`ifdef SERIAL_AND_RX_PARITY_EN
            err = ($countones(v0) % 2 != 0) || ($countones(v1) % 2 != 0);
`else
            err = 0;
`endif
            if (err) m_perr = 1;
            else begin
                m_valid = 1;
                m_o = W'(v0 & v1);
            end
        end
        m_busy = active;
    endtask

    // One clock: drive, advance model, sample 1 time unit after the edge.
    task automatic step(input bit rst, input bit st, input bit bv, input bit b0, input bit b1);
        RESET         = rst;
        bus.START     = st;
        bus.BIT_VALID = bv;
        bus.I0_S      = b0;
        bus.I1_S      = b1;
        @(posedge CLK);
        cyc++;
        model(rst, st, bv, b0, b1);
        #1;
        chk("O", 32'(bus.O), 32'(m_o));
        chk("O_VALID", 32'(bus.O_VALID), 32'(m_valid));
        chk("BUSY", 32'(bus.BUSY), 32'(m_busy));
`ifdef SERIAL_AND_RX_PARITY_EN
        chk("PAR_ERR", 32'(bus.PAR_ERR), 32'(m_perr));
`endif
        if (bus.O_VALID === 1'b1) begin
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
    endtask

    // Send a full frame (LSB first) with optional idle gap cycles between bits.
    task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b, input int gap, input bit bad0);
        logic [W:0] fa, fb;
        fa = {(^a) ^ bad0, a};
        fb = {^b, b};
        for (int i = 0; i < FLEN; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    step(0, 0, 0, 1'($urandom), 1'($urandom));
                    chk("BUSY_gap", 32'(bus.BUSY), 32'd1);
                end
            end
            step(0, i == 0, 1, fa[i], fb[i]);
        end
    endtask

    initial begin
        RESET = 1'b1;
        bus.START = 0; bus.BIT_VALID = 0; bus.I0_S = 0; bus.I1_S = 0;

        // Reset with other inputs active.
        step(1, 1, 1, 1, 1);
        step(1, 0, 1, 1, 1);
        chk("rst_O", 32'(bus.O), 32'd0);
        chk("rst_BUSY", 32'(bus.BUSY), 32'd0);
        chk("rst_O_VALID", 32'(bus.O_VALID), 32'd0);
        step(0, 0, 0, 0, 0);
        // BIT_VALID without START in IDLE is ignored.
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        chk("idle_ignore_BUSY", 32'(bus.BUSY), 32'd0);

        // Basic frame: I0=11, I1=01 -> 01, pulse right after the last bit.
        frame(2'b11, 2'b01, 0, 0);
        chk("basic_O", 32'(bus.O), 32'h1);
        chk("basic_O_VALID", 32'(bus.O_VALID), 32'd1);
        step(0, 0, 0, 0, 0);
        chk("basic_hold_O", 32'(bus.O), 32'h1);
        chk("basic_pulse_end", 32'(bus.O_VALID), 32'd0);

        // Same frame with a 3-cycle BIT_VALID gap.
        frame(2'b11, 2'b01, 3, 0);
        chk("gap_O", 32'(bus.O), 32'h1);
        chk("gap_O_VALID", 32'(bus.O_VALID), 32'd1);
        step(0, 0, 0, 0, 0);

        // Frame A abandoned after 1 bit by START of frame B (I0=10, I1=11).
        step(0, 1, 1, 1, 1);
        chk("abandon_BUSY", 32'(bus.BUSY), 32'd1);
        frame(2'b10, 2'b11, 0, 0);
        chk("abandon_O", 32'(bus.O), 32'h2);
        chk("abandon_O_VALID", 32'(bus.O_VALID), 32'd1);
        step(0, 0, 0, 0, 0);

        // Reset mid-frame, then non-START bits must not finish a frame.
        step(0, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        chk("midrst_O", 32'(bus.O), 32'd0);
        chk("midrst_BUSY", 32'(bus.BUSY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 1);
            chk("midrst_no_valid", 32'(bus.O_VALID), 32'd0);
        end

        // Back-to-back frames, second START lands in the DONE cycle.
        frame(2'b11, 2'b10, 0, 0);
        chk("b2b_first_O", 32'(bus.O), 32'h2);
        frame(2'b01, 2'b11, 0, 0);
        chk("b2b_second_O", 32'(bus.O), 32'h1);
        chk("b2b_spacing", 32'(last_pulse - prev_pulse), 32'(FLEN));
        step(0, 0, 0, 0, 0);

`ifdef SERIAL_AND_RX_PARITY_EN
        // Known result 01, then a frame with bad I0 parity must leave it alone.
        frame(2'b11, 2'b01, 0, 0);
        step(0, 0, 0, 0, 0);
        frame(2'b11, 2'b11, 0, 1);
        chk("par_err", 32'(bus.PAR_ERR), 32'd1);
        chk("par_no_valid", 32'(bus.O_VALID), 32'd0);
        chk("par_O_kept", 32'(bus.O), 32'h1);
        step(0, 0, 0, 0, 0);
        chk("par_err_pulse", 32'(bus.PAR_ERR), 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
